shadow_chain_collector: RTL and testbench
=========================================

# shadow_chain_collector

Receiving end of the shadow-capture dump chain: requests a dump from one shadow_capture instance, deserializes its chain output stream (data/valid/done) back into DFF_BITS-wide snapshot words, and buffers them in a small FIFO for a host readout port. Sits in the shadow (sh_clk) domain next to the shadow capture modules, e.g. recovering the 6-bit counter snapshots of the EXU ECL counters.

## Interface
- DFF_BITS, 6: width of one snapshot word, equal to the DFF_BITS of the attached capture module.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- TIMEOUT, 255: idle cycles tolerated in RECV before abort; 1..255.
- sh_clk  in  1  shadow/data clock; the only clock.
- sh_rst  in  1  reset, asynchronous, active-low (asserted at 0).
- dump_req  in  1  host pulse to start one dump.
- dump_en  out  1  drives the capture module's dump_en.
- ch_in  in  1  serial chain data (from ch_out).
- ch_in_vld  in  1  ch_in carries a valid bit this cycle.
- ch_in_done  in  1  chain finished.
- rd_data  out  DFF_BITS  FIFO head word.
- rd_vld  out  1  rd_data valid.
- rd_rdy  in  1  host consumes head when rd_vld & rd_rdy.
- busy  out  1  state ≠ IDLE.
- frame_bits  out  8  bits received in last completed dump, saturating at 255.
- overflow  out  1  sticky: word dropped on full FIFO.
- timeout  out  1  sticky: last dump aborted by timeout.

## Operation
- FSM: IDLE, RECV, CLOSE.
- IDLE: dump_req=1 → RECV; clears overflow, timeout, bit counter, shift register, idle counter. ch_in_vld/ch_in_done ignored in IDLE.
- RECV: dump_en=1. Each ch_in_vld cycle shifts ch_in in LSB-first (first bit received → bit 0), increments word bit index and frame bit counter (saturating 255), clears idle counter.
- Word complete (bit index reaches DFF_BITS-1 with vld): push assembled word, index → 0.
- ch_in_done in RECV: if vld in same cycle, that bit is accepted first. Remaining partial word (index ≠ 0) pushed zero-extended in upper bits. frame_bits updated. → CLOSE.
- CLOSE: dump_en=0; one cycle; → IDLE.
- Timeout: in RECV, idle counter increments on cycles with neither vld nor done; reaching TIMEOUT → timeout=1, partial word discarded, frame_bits updated with count so far, → IDLE directly (dump_en drops next cycle).
- dump_req outside IDLE ignored.
- FIFO: push succeeds if not full or a pop occurs same cycle; otherwise word dropped, overflow=1. Pop on rd_vld & rd_rdy. Pointers wrap modulo DEPTH with an extra wrap bit for full/empty.
- FIFO contents survive across dumps; only sh_rst clears them.

## Timing
- Reset (sh_rst=0, async): state IDLE; dump_en=0, rd_vld=0, rd_data=0, busy=0, frame_bits=0, overflow=0, timeout=0; FIFO empty.
- dump_req sampled at edge N in IDLE → dump_en=1, busy=1 from N+1.
- Last bit of a word accepted at edge M → rd_vld=1 (if FIFO was empty) from M+1; rd_data registered head.
- ch_in_done at edge D → state CLOSE and dump_en=0 from D+1; IDLE, busy=0 from D+2; frame_bits valid from D+1.
- Pop at edge P → next head (or rd_vld=0) from P+1. Full throughput: one push and one pop per cycle.
- Timeout: TIMEOUT-th consecutive idle cycle at edge T → IDLE, dump_en=0, timeout=1 from T+1.
- Reset mid-dump: immediate return to reset values; partial word and FIFO lost.

## Test plan
- DFF_BITS=6: dump_req, then vld bits 1,0,1,1,0,1 back-to-back, done with last bit → rd_data=6'h2D, rd_vld=1, frame_bits=6, dump_en low 1 cycle after done, busy low 2 cycles after.
- 9 bits 1,1,1,1,1,1,1,0,1 then done alone → words 6'h3F then 6'h05; frame_bits=9.
- rd_rdy=0, dump 5 words into DEPTH=4 → first 4 words held, fifth dropped, overflow=1; next dump_req clears overflow, FIFO intact.
- 3 bits then silence → timeout=1 exactly TIMEOUT idle cycles after last bit, no word pushed, frame_bits=3, busy=0.
- FIFO full, rd_rdy=1 on cycle word completes → push accepted, overflow stays 0, order preserved.
- sh_rst low mid-RECV (async, between edges) → dump_en, rd_vld, busy 0 immediately; after release, vld pulses in IDLE ignored.

Source files
------------

// File: rtl/shadow_chain_collector_if.sv
// Host/chain-side bus of shadow_chain_collector: dump request, serial chain input,
// FIFO readout handshake and status. 'slave' is the collector's view, 'master' the
// view of whatever drives it (capture module plus host).
interface shadow_chain_collector_if #(
    parameter int DFF_BITS = 6
);
    logic                dump_req;    // host pulse: start one dump
    logic                dump_en;     // to capture module: stream the chain
    logic                ch_in;       // serial chain data
    logic                ch_in_vld;   // ch_in carries a bit this cycle
    logic                ch_in_done;  // chain finished
    logic [DFF_BITS-1:0] rd_data;     // FIFO head word
    logic                rd_vld;      // rd_data valid
    logic                rd_rdy;      // host consumes head on rd_vld & rd_rdy
    logic                busy;        // collector not idle
    logic [7:0]          frame_bits;  // bits in last completed dump (saturating)
    logic                overflow;    // sticky: word dropped on full FIFO
    logic                timeout;     // sticky: last dump aborted by timeout

    modport slave (
        input  dump_req, ch_in, ch_in_vld, ch_in_done, rd_rdy,
        output dump_en, rd_data, rd_vld, busy, frame_bits, overflow, timeout
    );

    modport master (
        output dump_req, ch_in, ch_in_vld, ch_in_done, rd_rdy,
        input  dump_en, rd_data, rd_vld, busy, frame_bits, overflow, timeout
    );
endinterface

// File: rtl/shadow_chain_collector.sv
// Purpose : requests a shadow-chain dump, deserializes the LSB-first bit stream into
//           DFF_BITS-wide words and queues them in a DEPTH-entry FIFO for the host.
// Latency : word visible on rd_data one cycle after its last bit; dump_en one cycle after dump_req.
// Backpr. : rd_vld/rd_rdy on readout; the chain cannot be stalled, so a word arriving
//           at a full FIFO (with no pop that cycle) is dropped and flags overflow.
// Ports   : sh_clk, sh_rst (async, active-low) plus bus (slave modport):
//           dump_req/dump_en, ch_in/ch_in_vld/ch_in_done, rd_data/rd_vld/rd_rdy,
//           busy, frame_bits, overflow, timeout.
module shadow_chain_collector #(
    parameter int DFF_BITS = 6,
    parameter int DEPTH    = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                         sh_clk,
    input  logic                         sh_rst,
    shadow_chain_collector_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (DFF_BITS > 1) ? $clog2(DFF_BITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DFF_BITS-1:0] sr_q, sr_d;
    logic [7:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          idle_q, idle_d;
    logic [7:0]          frame_q, frame_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;

    logic                push;
    logic                push_ok;
    logic                pop;
    logic [DFF_BITS-1:0] push_word;
    logic [DFF_BITS-1:0] word_v;

    logic [DFF_BITS-1:0] mem_q [DEPTH];
    logic [AW:0]         wr_q, rd_q;
    logic                fifo_full;
    logic                fifo_empty;

    // Extra wrap bit distinguishes full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop        = !fifo_empty && bus.rd_rdy;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        idle_d    = idle_q;
        frame_d   = frame_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        push_word = '0;
        word_v    = sr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.dump_req) begin
                    state_d   = ST_RECV;
                    ovf_d     = 1'b0;
                    tmo_d     = 1'b0;
                    bit_cnt_d = '0;
                    sr_d      = '0;
                    idx_d     = '0;
                    idle_d    = '0;
                end
            end

            ST_RECV: begin
                if (bus.ch_in_vld) begin
                    word_v[idx_q] = bus.ch_in;
                    idle_d        = '0;
                    bit_cnt_d     = (bit_cnt_q == 8'hFF) ? 8'hFF : bit_cnt_q + 8'd1;
                    if (idx_q == IW'(DFF_BITS - 1)) begin
                        push      = 1'b1;
                        push_word = word_v;
                        sr_d      = '0;
                        idx_d     = '0;
                    end else begin
                        sr_d  = word_v;
                        idx_d = idx_q + IW'(1);
                    end
                end

                if (bus.ch_in_done) begin
                    // Bit of this cycle (if any) is already folded into sr_d/idx_d.
                    // A completed word resets idx_d, so at most one push per cycle.
                    if (idx_d != '0) begin
                        push      = 1'b1;
                        push_word = sr_d;
                    end
                    sr_d    = '0;
                    idx_d   = '0;
                    frame_d = bit_cnt_d;
                    state_d = ST_CLOSE;
                end else if (!bus.ch_in_vld) begin
                    if (idle_q == 8'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        frame_d = bit_cnt_q;
                        sr_d    = '0;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end

            ST_CLOSE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sh_clk or negedge sh_rst) begin
        if (!sh_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            idle_q    <= '0;
            frame_q   <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            idle_q    <= idle_d;
            frame_q   <= frame_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            if (push_ok) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observable between push and pop.
    always_ff @(posedge sh_clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= push_word;
        end
    end

    assign bus.dump_en    = (state_q == ST_RECV);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rd_vld     = !fifo_empty;
    // Head is forced to zero while empty so reset/empty readout is deterministic.
    assign bus.rd_data    = fifo_empty ? '0 : mem_q[rd_q[AW-1:0]];
    assign bus.frame_bits = frame_q;
    assign bus.overflow   = ovf_q;
    assign bus.timeout    = tmo_q;

endmodule

// File: tb/tb_shadow_chain_collector.sv
module tb_shadow_chain_collector;

    logic sh_clk = 1'b0;
    logic sh_rst = 1'b0;
    always #5 sh_clk = ~sh_clk;

    shadow_chain_collector_if #(.DFF_BITS(6)) bus ();

    shadow_chain_collector #(.DFF_BITS(6), .DEPTH(4), .TIMEOUT(255)) dut (
        .sh_clk (sh_clk),
        .sh_rst (sh_rst),
        .bus    (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic       req;
        logic       ch;
        logic       vld;
        logic       done;
        logic       rdy;
        logic       exp_en;
        logic       exp_busy;
        logic       exp_rvld;
        logic [5:0] exp_data;
        logic [7:0] exp_frame;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge sample them, settle.
    task automatic drive(input logic req, input logic ch, input logic vld,
                         input logic done, input logic rdy);
        @(negedge sh_clk);
        bus.dump_req   = req;
        bus.ch_in      = ch;
        bus.ch_in_vld  = vld;
        bus.ch_in_done = done;
        bus.rd_rdy     = rdy;
        @(posedge sh_clk);
        #1;
    endtask

    task automatic send_word(input logic [5:0] w, input logic done_last, input logic rdy);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, w[i], 1'b1, done_last && (i == 5), rdy);
        end
    endtask

    initial begin
        // req ch vld done rdy | en busy rvld data frame
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h2D, 8'd6};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2D, 8'd6};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8'd6};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd6};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd6};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd6};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd6};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd6};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 8'd6};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3F, 8'd6};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3F, 8'd6};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3F, 8'd6};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3F, 8'd6};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'h3F, 8'd9};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h05, 8'd9};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8'd9};
        tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 8'd9};

        bus.dump_req   = 1'b0;
        bus.ch_in      = 1'b0;
        bus.ch_in_vld  = 1'b0;
        bus.ch_in_done = 1'b0;
        bus.rd_rdy     = 1'b0;

        // Reset state
        repeat (3) @(posedge sh_clk);
        #1;
        chk("rst_dump_en",  32'(bus.dump_en),    32'd0);
        chk("rst_busy",     32'(bus.busy),       32'd0);
        chk("rst_rd_vld",   32'(bus.rd_vld),     32'd0);
        chk("rst_rd_data",  32'(bus.rd_data),    32'd0);
        chk("rst_frame",    32'(bus.frame_bits), 32'd0);
        chk("rst_overflow", 32'(bus.overflow),   32'd0);
        chk("rst_timeout",  32'(bus.timeout),    32'd0);
        @(negedge sh_clk);
        sh_rst = 1'b1;

        // Table: single 6-bit word with done on last bit, then 9-bit frame
        for (int v = 0; v < 23; v++) begin
            drive(tbl[v].req, tbl[v].ch, tbl[v].vld, tbl[v].done, tbl[v].rdy);
            chk($sformatf("v%0d_dump_en", v), 32'(bus.dump_en),    32'(tbl[v].exp_en));
            chk($sformatf("v%0d_busy", v),    32'(bus.busy),       32'(tbl[v].exp_busy));
            chk($sformatf("v%0d_rd_vld", v),  32'(bus.rd_vld),     32'(tbl[v].exp_rvld));
            chk($sformatf("v%0d_rd_data", v), 32'(bus.rd_data),    32'(tbl[v].exp_data));
            chk($sformatf("v%0d_frame", v),   32'(bus.frame_bits), 32'(tbl[v].exp_frame));
            chk($sformatf("v%0d_ovf", v),     32'(bus.overflow),   32'd0);
        end

        // Overflow: five words into a 4-deep FIFO with no reads
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            send_word(6'(k), k == 5, 1'b0);
        end
        chk("ovf_set",      32'(bus.overflow),   32'd1);
        chk("ovf_frame",    32'(bus.frame_bits), 32'd30);
        chk("ovf_head",     32'(bus.rd_data),    32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_cleared",  32'(bus.overflow),   32'd0);
        chk("ovf_busy",     32'(bus.busy),       32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_empty_frame", 32'(bus.frame_bits), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_rd%0d_vld", k),  32'(bus.rd_vld),  32'd1);
            chk($sformatf("ovf_rd%0d_data", k), 32'(bus.rd_data), 32'(k));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("ovf_drained", 32'(bus.rd_vld), 32'd0);

        // Full FIFO with a pop on the cycle the next word completes
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(6'd10, 1'b0, 1'b0);
        send_word(6'd11, 1'b0, 1'b0);
        send_word(6'd12, 1'b0, 1'b0);
        send_word(6'd13, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // 14 = 6'b001110, LSB first
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("fullpop_ovf",  32'(bus.overflow), 32'd0);
        chk("fullpop_head", 32'(bus.rd_data),  32'd11);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 11; k <= 14; k++) begin
            chk($sformatf("fullpop_rd%0d", k), 32'(bus.rd_data), 32'(k));
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("fullpop_drained", 32'(bus.rd_vld), 32'd0);

        // Timeout: 3 bits then silence
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 254; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("tmo_not_yet",     32'(bus.timeout), 32'd0);
        chk("tmo_busy_before", 32'(bus.busy),    32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_set",     32'(bus.timeout),    32'd1);
        chk("tmo_busy",    32'(bus.busy),       32'd0);
        chk("tmo_dump_en", 32'(bus.dump_en),    32'd0);
        chk("tmo_frame",   32'(bus.frame_bits), 32'd3);
        chk("tmo_no_word", 32'(bus.rd_vld),     32'd0);

        // Asynchronous reset in the middle of a dump
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_cleared", 32'(bus.timeout), 32'd0);
        send_word(6'h15, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_vld",  32'(bus.rd_vld),  32'd1);
        chk("pre_rst_data", 32'(bus.rd_data), 32'h15);
        #2;
        sh_rst = 1'b0;
        #1;
        chk("arst_dump_en", 32'(bus.dump_en),    32'd0);
        chk("arst_rd_vld",  32'(bus.rd_vld),     32'd0);
        chk("arst_busy",    32'(bus.busy),       32'd0);
        chk("arst_frame",   32'(bus.frame_bits), 32'd0);
        @(negedge sh_clk);
        sh_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_busy",  32'(bus.busy),       32'd0);
        chk("post_rst_vld",   32'(bus.rd_vld),     32'd0);
        chk("post_rst_frame", 32'(bus.frame_bits), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
